inst_queue: RTL and testbench
=============================

Name: inst_queue

Overview:
- Fetch-and-buffer stage directly upstream of the decoder.
- Generates sequential fetch PCs and issues one word request at a time to the instruction cache.
- Buffers returned {inst, pc} pairs in a circular FIFO and presents the head entry to the decoder.
- On a redirect (clear) it flushes the FIFO, drops any in-flight response and restarts fetch at the redirect PC.

Parameters:
- DEPTH, 16, FIFO entries (power of two, ≥2)
- PTR_W, 4, log2(DEPTH)
- RESET_PC, 32'h0, first fetch address after reset

Ports:
- clk_in  in  1  clock
- rst_in  in  1  synchronous active-high reset
- rdy_in  in  1  global ready; low freezes all state (rst_in still takes effect)
- clear  in  1  redirect/flush from commit
- jump_pc  in  32  new fetch PC, valid with clear
- ic_req  out  1  fetch request strobe, one cycle
- ic_addr  out  32  fetch address, valid with ic_req
- ic_valid  in  1  response strobe
- ic_data  in  32  returned instruction word
- Get_Inst  in  1  decoder pop request
- Inst_out  out  32  head instruction
- pc_out  out  32  head PC
- en_out  out  1  head entry valid (== !IQ_isempty)
- IQ_isempty  out  1  FIFO empty
- IQ_isfull  out  1  FIFO full

Behaviour:
- Reset: ic_req=0, ic_addr=0, fetch_pc=RESET_PC, head=tail=count=0, state=IDLE, IQ_isempty=1, IQ_isfull=0, en_out=0. Inst_out and pc_out are driven from the head slot; their value while empty is don't-care.
- Storage: DEPTH×64-bit array. Head/tail are PTR_W-bit and wrap naturally. count is PTR_W+1 bits. IQ_isempty=(count==0), IQ_isfull=(count==DEPTH). Both are combinational from count.
- Output: Inst_out/pc_out are combinational reads of the head slot. A pop occurs at a clock edge when Get_Inst && !IQ_isempty && rdy_in && !clear. Get_Inst while empty is ignored.
- FSM:
  - IDLE: when count + outstanding < DEPTH, pulse ic_req with ic_addr=fetch_pc and go to WAIT.
  - WAIT: on ic_valid, write {ic_data, fetch_pc} at tail, tail++, fetch_pc += 4 (mod 2^32), then go to IDLE. Next request no earlier than the following cycle, so max throughput is 1 instr / 2 cycles.
  - DISCARD: entered when clear arrives in WAIT. On ic_valid, drop the data and go to IDLE.
- Latency: response → visible at head the next cycle (registered write).
- Simultaneous events:
  - Push and pop in the same cycle: count unchanged. This is legal even when full, because the push reserves a slot via the IDLE check.
  - clear has priority over push/pop. head=tail=count=0 and fetch_pc=jump_pc.
    - In IDLE: the next state issues at jump_pc the cycle after.
    - In WAIT without ic_valid: go to DISCARD.
    - In WAIT with ic_valid the same cycle: the response is dropped and the next state is IDLE.
    - In DISCARD: stay in DISCARD; fetch_pc is still updated.
- rdy_in=0: no state, pointer or FSM change; ic_req forced 0; a response arriving while rdy_in=0 is held by the cache (cache contract).
- Reset mid-operation: returns to reset values. A later stray ic_valid in IDLE is ignored.

Optional Feature:
- IQ_JAL_REDIRECT_EN
  - Defined: a response with ic_data[6:0]==7'b1101111 (JAL) sets the next fetch_pc to pc + sign-extended J-immediate {imm[20],imm[10:1],imm[11],imm[19:12],0} instead of pc+4. The JAL word itself is still enqueued unchanged.
  - Undefined: always pc+4.

Decomposition:
- Shared def package/header:
  - InstSize/AddrSize widths
  - OPC_JAL opcode constant
  - IQ state encodings (IQ_IDLE, IQ_WAIT, IQ_DISCARD)
- One natural sub-module, iq_fifo: circular buffer with push/pop/flush, count, full/empty. The FSM and PC logic stay in inst_queue.

Test Plan:
- Reset, then cache answers every request after 1 cycle with data=addr^32'hA5A5A5A5 → entries at PCs 0,4,8,… appear in order; en_out rises 3 cycles after reset release.
- Hold Get_Inst=0 → exactly 16 entries accepted, IQ_isfull=1, no further ic_req; one pop → one new request, refills to full.
- clear with jump_pc=32'h1000 while in WAIT, response 2 cycles later → response dropped, FIFO empty, next ic_addr=32'h1000.
- clear and ic_valid in the same cycle with FIFO holding 5 entries → count=0, no enqueue, next ic_addr=jump_pc.
- Get_Inst pulses while empty, and rdy_in=0 for 4 cycles mid-stream → no pointer movement, no lost or duplicated PCs.
- With IQ_JAL_REDIRECT_EN, fetch at 32'h8 returns 32'h0100006F (jal x0,+16) → JAL enqueued with pc 32'h8, next ic_addr=32'h18. Without the macro, next ic_addr=32'hC.

Source files
------------

// File: rtl/inst_queue_pkg.sv
// Shared widths, opcode constant and FSM states for the fetch/instruction-queue stage.
package inst_queue_pkg;

    localparam int unsigned InstSize = 32;
    localparam int unsigned AddrSize = 32;

    localparam logic [6:0] OPC_JAL = 7'b1101111;

    typedef enum logic [1:0] {
        IQ_IDLE    = 2'd0,
        IQ_WAIT    = 2'd1,
        IQ_DISCARD = 2'd2
    } iq_state_e;

    // RISC-V J-type target: pc + sext({imm[20], imm[10:1], imm[11], imm[19:12], 0})
    function automatic logic [AddrSize-1:0] jal_target(input logic [AddrSize-1:0] pc,
                                                       input logic [InstSize-1:0] inst);
        logic [AddrSize-1:0] imm;
        imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        return pc + imm;
    endfunction

endpackage

// File: rtl/inst_queue_iq_fifo.sv
// Circular buffer of {inst, pc} entries with push/pop/flush; head slot read combinationally.
module iq_fifo
    import inst_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned PTR_W = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;

    assign rdata_o = mem_q[head_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_i) tail_d = tail_q + 1'b1;
            if (pop_i)  head_d = head_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) mem_q[tail_q] <= wdata_i;
    end

endmodule

// File: rtl/inst_queue.sv
// Sequential fetch FSM feeding a {inst, pc} FIFO for the decoder.
// Optional `IQ_JAL_REDIRECT_EN: follow JAL targets when computing the next fetch PC.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int unsigned         DEPTH    = 16,
    parameter int unsigned         PTR_W    = 4,
    parameter logic [AddrSize-1:0] RESET_PC = 32'h0
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                clear,
    input  logic [AddrSize-1:0] jump_pc,
    output logic                ic_req,
    output logic [AddrSize-1:0] ic_addr,
    input  logic                ic_valid,
    input  logic [InstSize-1:0] ic_data,
    input  logic                Get_Inst,
    output logic [InstSize-1:0] Inst_out,
    output logic [AddrSize-1:0] pc_out,
    output logic                en_out,
    output logic                IQ_isempty,
    output logic                IQ_isfull
);

    iq_state_e             state_q, state_d;
    logic [AddrSize-1:0]   fetch_pc_q, fetch_pc_d;
    logic [AddrSize-1:0]   ic_addr_q, ic_addr_d;
    logic                  ic_req_q, ic_req_d;
    logic [AddrSize-1:0]   next_pc;
    logic                  push, pop, flush;
    logic [InstSize+AddrSize-1:0] head_entry;

    assign ic_req   = ic_req_q;
    assign ic_addr  = ic_addr_q;
    assign Inst_out = head_entry[InstSize+AddrSize-1:AddrSize];
    assign pc_out   = head_entry[AddrSize-1:0];
    assign en_out   = !IQ_isempty;

`ifdef IQ_JAL_REDIRECT_EN
    assign next_pc = (ic_data[6:0] == OPC_JAL) ? jal_target(fetch_pc_q, ic_data)
                                               : fetch_pc_q + 32'd4;
`else
    assign next_pc = fetch_pc_q + 32'd4;
`endif

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        ic_addr_d  = ic_addr_q;
        ic_req_d   = 1'b0;
        push       = 1'b0;
        flush      = 1'b0;
        pop        = rdy_in && Get_Inst && !IQ_isempty && !clear;
        if (rdy_in) begin
            if (clear) begin
                flush      = 1'b1;
                fetch_pc_d = jump_pc;
                // An in-flight request must still be drained unless its response lands now
                if (state_q == IQ_WAIT || state_q == IQ_DISCARD)
                    state_d = ic_valid ? IQ_IDLE : IQ_DISCARD;
                else
                    state_d = IQ_IDLE;
            end else begin
                case (state_q)
                    IQ_IDLE: begin
                        // Nothing is outstanding in IDLE, so a free slot is enough to issue
                        if (!IQ_isfull) begin
                            ic_req_d  = 1'b1;
                            ic_addr_d = fetch_pc_q;
                            state_d   = IQ_WAIT;
                        end
                    end
                    IQ_WAIT: begin
                        if (ic_valid) begin
                            push       = 1'b1;
                            fetch_pc_d = next_pc;
                            state_d    = IQ_IDLE;
                        end
                    end
                    IQ_DISCARD: begin
                        if (ic_valid) state_d = IQ_IDLE;
                    end
                    default: state_d = IQ_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= IQ_IDLE;
            fetch_pc_q <= RESET_PC;
            ic_addr_q  <= '0;
            ic_req_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            ic_addr_q  <= ic_addr_d;
            ic_req_q   <= ic_req_d;
        end
    end

    iq_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .WIDTH (InstSize + AddrSize)
    ) u_fifo (
        .clk_i   (clk_in),
        .rst_i   (rst_in),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .wdata_i ({ic_data, fetch_pc_q}),
        .rdata_o (head_entry),
        .empty_o (IQ_isempty),
        .full_o  (IQ_isfull)
    );

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue with a small behavioural instruction-cache responder.
module tb_inst_queue;

    logic        clk = 1'b0;
    logic        rst_in, rdy_in, clear, ic_valid, Get_Inst;
    logic [31:0] jump_pc, ic_data;
    logic        ic_req, en_out, IQ_isempty, IQ_isfull;
    logic [31:0] ic_addr, Inst_out, pc_out;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    int unsigned req_cnt = 0;
    int unsigned ok_cnt  = 0;
    bit          pend    = 1'b0;
    int          cnt     = 0;
    int          lat     = 1;
    bit          jal_mode = 1'b0;
    logic [31:0] pend_addr = '0;
    logic [31:0] last_req  = '0;

    always #5 clk = ~clk;

    inst_queue #(
        .DEPTH    (16),
        .PTR_W    (4),
        .RESET_PC (32'h0)
    ) dut (
        .clk_in     (clk),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .clear      (clear),
        .jump_pc    (jump_pc),
        .ic_req     (ic_req),
        .ic_addr    (ic_addr),
        .ic_valid   (ic_valid),
        .ic_data    (ic_data),
        .Get_Inst   (Get_Inst),
        .Inst_out   (Inst_out),
        .pc_out     (pc_out),
        .en_out     (en_out),
        .IQ_isempty (IQ_isempty),
        .IQ_isfull  (IQ_isfull)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] cache_word(input logic [31:0] a);
        if (jal_mode && a == 32'h8) return 32'h0100006F;
        return a ^ 32'hA5A5A5A5;
    endfunction

    // One clock; then the cache retires/delivers/accepts like a 1..N cycle memory.
    task automatic tick();
        @(posedge clk);
        #1;
        if (ic_valid && rdy_in) begin
            ic_valid = 1'b0;
            if (!clear) ok_cnt++;
        end
        if (pend) begin
            cnt--;
            if (cnt == 0) begin
                ic_valid = 1'b1;
                ic_data  = cache_word(pend_addr);
                pend     = 1'b0;
            end
        end
        if (ic_req) begin
            req_cnt++;
            last_req  = ic_addr;
            pend      = 1'b1;
            cnt       = lat;
            pend_addr = ic_addr;
        end
    endtask

    task automatic do_reset();
        rst_in   = 1'b1;
        rdy_in   = 1'b1;
        clear    = 1'b0;
        Get_Inst = 1'b0;
        ic_valid = 1'b0;
        pend     = 1'b0;
        tick();
        tick();
        chk("rst_req",   ic_req,     0);
        chk("rst_addr",  ic_addr,    0);
        chk("rst_empty", IQ_isempty, 1);
        chk("rst_full",  IQ_isfull,  0);
        chk("rst_en",    en_out,     0);
        rst_in  = 1'b0;
        req_cnt = 0;
        ok_cnt  = 0;
    endtask

    task automatic drain(input int unsigned npop, input logic [31:0] first_pc);
        logic [31:0] exp_pc;
        int unsigned pops;
        exp_pc = first_pc;
        pops   = 0;
        for (int i = 0; i < 300 && pops < npop; i++) begin
            if (en_out) begin
                chk("drain_pc",   pc_out,   exp_pc);
                chk("drain_inst", Inst_out, cache_word(exp_pc));
                Get_Inst = 1'b1;
                exp_pc   = exp_pc + 32'd4;
                pops++;
            end else begin
                Get_Inst = 1'b0;
            end
            tick();
        end
        Get_Inst = 1'b0;
        chk("drain_done", pops, npop);
    endtask

    initial begin
        int unsigned rc;
        bit          done;
        jump_pc = '0;
        ic_data = '0;
        do_reset();

        // first entry becomes visible on the third edge after reset release
        tick();
        chk("first_req",  ic_req,  1);
        chk("first_addr", ic_addr, 32'h0);
        tick();
        chk("en_early", en_out, 0);
        tick();
        chk("en_rise",   en_out,   1);
        chk("head_pc0",  pc_out,   32'h0);
        chk("head_inst", Inst_out, 32'hA5A5A5A5);

        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            tick();
            done = IQ_isfull;
        end
        chk("fill_full", IQ_isfull, 1);
        chk("fill_reqs", req_cnt, 16);
        for (int i = 0; i < 10; i++) tick();
        chk("hold_reqs", req_cnt, 16);
        chk("hold_head", pc_out, 32'h0);

        Get_Inst = 1'b1;
        tick();
        Get_Inst = 1'b0;
        chk("pop_head", pc_out, 32'h4);
        chk("pop_full", IQ_isfull, 0);
        for (int i = 0; i < 10; i++) tick();
        chk("refill_reqs", req_cnt, 17);
        chk("refill_full", IQ_isfull, 1);
        chk("refill_addr", last_req, 32'h40);
        drain(20, 32'h4);

        // redirect while a request is outstanding; its late response must vanish
        lat  = 2;
        rc   = req_cnt;
        done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            tick();
            done = (req_cnt != rc);
        end
        chk("wait_req_seen", done, 1);
        clear   = 1'b1;
        jump_pc = 32'h1000;
        tick();
        clear = 1'b0;
        chk("clr_empty", IQ_isempty, 1);
        tick();
        chk("disc_noreq", ic_req, 0);
        tick();
        chk("disc_noreq2", ic_req, 0);
        chk("disc_empty",  IQ_isempty, 1);
        tick();
        chk("redir_req",  ic_req,  1);
        chk("redir_addr", ic_addr, 32'h1000);
        lat    = 1;
        ok_cnt = 0;

        // clear coinciding with a response, five entries already buffered
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            tick();
            done = (ok_cnt == 5) && ic_valid;
        end
        chk("five_seen", done, 1);
        chk("five_head", pc_out, 32'h1000);
        clear   = 1'b1;
        jump_pc = 32'h2000;
        tick();
        clear = 1'b0;
        chk("cv_empty", IQ_isempty, 1);
        chk("cv_noreq", ic_req, 0);
        ok_cnt   = 0;
        Get_Inst = 1'b1;
        tick();
        chk("cv_req",    ic_req,     1);
        chk("cv_addr",   ic_addr,    32'h2000);
        chk("pop_empty", IQ_isempty, 1);
        tick();
        chk("pop_empty2", IQ_isempty, 1);
        Get_Inst = 1'b0;
        tick();
        chk("cv_en",   en_out,   1);
        chk("cv_pc",   pc_out,   32'h2000);
        chk("cv_inst", Inst_out, 32'h2000 ^ 32'hA5A5A5A5);

        // rdy_in low with pops requested: nothing may move
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            tick();
            done = (ok_cnt >= 3);
        end
        chk("three_seen", done, 1);
        chk("pre_stall_pc", pc_out, 32'h2000);
        rdy_in   = 1'b0;
        Get_Inst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall_req", ic_req, 0);
            chk("stall_pc",  pc_out, 32'h2000);
        end
        rdy_in = 1'b1;
        drain(8, 32'h2000);

        // mid-stream reset, then the JAL word at pc 8
        jal_mode = 1'b1;
        do_reset();
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            tick();
            done = (req_cnt == 4);
        end
        chk("jal_reqs", done, 1);
`ifdef IQ_JAL_REDIRECT_EN
        chk("jal_next", last_req, 32'h18);
`else
        chk("jal_next", last_req, 32'hC);
`endif
        drain(3, 32'h0);
        chk("jal_word", cache_word(32'h8), 32'h0100006F);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
